// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC control bundle; slave is the PC generator, master drives redirects and observes the PC.
interface pc_gen_if #(parameter int ADDR_W = 32);
  logic              stall_i;
  logic              br_valid_i;
  logic [ADDR_W-1:0] br_target_i;
  logic              trap_valid_i;
  logic [ADDR_W-1:0] trap_target_i;
  logic              btb_upd_i;
  logic [ADDR_W-1:0] btb_upd_pc_i;
  logic [ADDR_W-1:0] btb_upd_tgt_i;
  logic [ADDR_W-1:0] pc_o;
  logic              pc_valid_o;
  logic              pred_taken_o;
  logic              pending_o;
  modport slave (
    input  stall_i, br_valid_i, br_target_i, trap_valid_i, trap_target_i,
           btb_upd_i, btb_upd_pc_i, btb_upd_tgt_i,
    output pc_o, pc_valid_o, pred_taken_o, pending_o
  );
  modport master (
    output stall_i, br_valid_i, br_target_i, trap_valid_i, trap_target_i,
           btb_upd_i, btb_upd_pc_i, btb_upd_tgt_i,
    input  pc_o, pc_valid_o, pred_taken_o, pending_o
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with trap/branch redirects, one-entry pending buffer and boot state.
// Define PC_BTB_EN to build the direct-mapped branch target buffer for next-PC prediction.
module pc_gen #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              STEP      = 4,
  parameter int              BTB_DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam int SW = $clog2(STEP);
  typedef enum logic {BOOT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, sel, nxt, btb_tgt;
  logic valid_q, valid_d, pred_q, pred_d, pend_q, pend_d, pend_trap_q, pend_trap_d, redir, hit;
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(STEP - 1);
  endfunction
`ifdef PC_BTB_EN
  localparam int BW = $clog2(BTB_DEPTH);
  localparam int TW = ADDR_W - SW - BW;
  logic [BTB_DEPTH-1:0] btb_v_q;
  logic [TW-1:0]        btb_tag_q [BTB_DEPTH];
  logic [ADDR_W-1:0]    btb_tgt_q [BTB_DEPTH];
  logic [BW-1:0]        idx, upd_idx;
  assign idx     = pc_q[SW +: BW];
  assign upd_idx = bus.btb_upd_pc_i[SW +: BW];
  assign hit     = btb_v_q[idx] && btb_tag_q[idx] == pc_q[ADDR_W-1:SW+BW];
  assign btb_tgt = btb_tgt_q[idx];
  always_ff @(posedge clk)
    if (rst) btb_v_q <= '0;
    else if (bus.btb_upd_i) btb_v_q[upd_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (bus.btb_upd_i) begin
      btb_tag_q[upd_idx] <= bus.btb_upd_pc_i[ADDR_W-1:SW+BW];
      btb_tgt_q[upd_idx] <= align(bus.btb_upd_tgt_i);
    end
`else
  logic unused_btb;
  assign unused_btb = ^{bus.btb_upd_i, bus.btb_upd_pc_i, bus.btb_upd_tgt_i};
  assign hit        = 1'b0;
  assign btb_tgt    = '0;
`endif
  assign redir = bus.trap_valid_i | bus.br_valid_i | pend_q;
  assign sel   = align(bus.trap_valid_i ? bus.trap_target_i : bus.br_valid_i ? bus.br_target_i : pend_tgt_q);
  assign nxt   = hit ? btb_tgt : pc_q + ADDR_W'(STEP);
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    pred_d      = pred_q;
    pend_d      = pend_q;
    pend_trap_d = pend_trap_q;
    pend_tgt_d  = pend_tgt_q;
    if (bus.stall_i) begin
      // a buffered trap must survive any later branch
      if (bus.trap_valid_i || (bus.br_valid_i && !(pend_q && pend_trap_q))) begin
        pend_d      = 1'b1;
        pend_trap_d = bus.trap_valid_i;
        pend_tgt_d  = align(bus.trap_valid_i ? bus.trap_target_i : bus.br_target_i);
      end
    end else begin
      pend_d      = 1'b0;
      pend_trap_d = 1'b0;
      state_d     = RUN;
      valid_d     = 1'b1;
      pc_d        = redir ? sel : state_q == BOOT ? pc_q : nxt;
      pred_d      = !redir && state_q == RUN && hit;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      pred_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      pred_q      <= pred_d;
      pend_q      <= pend_d;
      pend_trap_q <= pend_trap_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  assign bus.pc_o         = pc_q;
  assign bus.pc_valid_o   = valid_q;
  assign bus.pred_taken_o = pred_q;
  assign bus.pending_o    = pend_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen with RESET_PC=0x100.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  pc_gen_if #(.ADDR_W(32)) bus ();
  pc_gen #(.ADDR_W(32), .RESET_PC(32'h100), .STEP(4), .BTB_DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic st, input logic bv, input logic [31:0] bt, input logic tv, input logic [31:0] tt);
    bus.stall_i = st;
    bus.br_valid_i = bv;
    bus.br_target_i = bt;
    bus.trap_valid_i = tv;
    bus.trap_target_i = tt;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    bus.btb_upd_i = 0;
    bus.btb_upd_pc_i = 0;
    bus.btb_upd_tgt_i = 0;
    step(); step();
    chk("rst_pc", bus.pc_o, 32'h100);
    chk("rst_valid", {31'b0, bus.pc_valid_o}, 0);
    chk("rst_pend", {31'b0, bus.pending_o}, 0);
    chk("rst_pred", {31'b0, bus.pred_taken_o}, 0);
    rst = 0;
    step();
    chk("boot_pc", bus.pc_o, 32'h100);
    chk("boot_valid", {31'b0, bus.pc_valid_o}, 1);
    step(); chk("run_104", bus.pc_o, 32'h104);
    step(); chk("run_108", bus.pc_o, 32'h108);
    drive(0, 1, 32'h2002, 0, 0);
    step(); drive(0, 0, 0, 0, 0);
    chk("br_align", bus.pc_o, 32'h2000);
    chk("br_pend", {31'b0, bus.pending_o}, 0);
    step(); chk("br_next", bus.pc_o, 32'h2004);
    drive(1, 1, 32'h400, 0, 0);
    step();
    chk("st1_pc", bus.pc_o, 32'h2004);
    chk("st1_pend", {31'b0, bus.pending_o}, 1);
    drive(1, 0, 0, 1, 32'h80);
    step();
    chk("st2_pc", bus.pc_o, 32'h2004);
    drive(1, 1, 32'h400, 0, 0);
    step();
    chk("st3_pc", bus.pc_o, 32'h2004);
    chk("st3_pend", {31'b0, bus.pending_o}, 1);
    drive(0, 0, 0, 0, 0);
    step();
    chk("rel_trap_kept", bus.pc_o, 32'h80);
    chk("rel_pend", {31'b0, bus.pending_o}, 0);
    step(); chk("rel_next", bus.pc_o, 32'h84);
    drive(0, 1, 32'h400, 1, 32'h80);
    step(); drive(0, 0, 0, 0, 0);
    chk("prio_unstalled", bus.pc_o, 32'h80);
    drive(1, 1, 32'h600, 1, 32'h200);
    step(); drive(0, 0, 0, 0, 0);
    step(); chk("prio_stalled", bus.pc_o, 32'h200);
    drive(1, 1, 32'h700, 0, 0);
    step(); drive(1, 1, 32'h800, 0, 0);
    step(); drive(0, 0, 0, 0, 0);
    step(); chk("br_overwrite", bus.pc_o, 32'h800);
    drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(); drive(0, 0, 0, 0, 0);
    chk("wrap_top", bus.pc_o, 32'hFFFF_FFFC);
    step(); chk("wrap_zero", bus.pc_o, 32'h0);
    drive(1, 0, 0, 0, 0);
    step(); chk("stall_hold", bus.pc_o, 32'h0);
    drive(1, 1, 32'h500, 0, 0);
    step(); chk("pre_rst_pend", {31'b0, bus.pending_o}, 1);
    rst = 1;
    step();
    chk("rst2_pc", bus.pc_o, 32'h100);
    chk("rst2_pend", {31'b0, bus.pending_o}, 0);
    chk("rst2_valid", {31'b0, bus.pc_valid_o}, 0);
    rst = 0;
    drive(1, 0, 0, 0, 0);
    step(); chk("boot_stall_valid", {31'b0, bus.pc_valid_o}, 0);
    drive(0, 0, 0, 0, 0);
    step();
    chk("reboot_pc", bus.pc_o, 32'h100);
    chk("reboot_valid", {31'b0, bus.pc_valid_o}, 1);
    bus.btb_upd_i = 1;
    bus.btb_upd_pc_i = 32'h10;
    bus.btb_upd_tgt_i = 32'h300;
    drive(1, 0, 0, 0, 0);
    step();
    bus.btb_upd_i = 0;
    drive(0, 1, 32'h10, 0, 0);
    step(); drive(0, 0, 0, 0, 0);
    chk("btb_at_10", bus.pc_o, 32'h10);
    chk("btb_pred0", {31'b0, bus.pred_taken_o}, 0);
    step();
`ifdef PC_BTB_EN
    chk("btb_hit_pc", bus.pc_o, 32'h300);
    chk("btb_hit_pred", {31'b0, bus.pred_taken_o}, 1);
    step();
    chk("btb_after_pc", bus.pc_o, 32'h304);
`else
    chk("nobtb_pc", bus.pc_o, 32'h14);
    chk("nobtb_pred", {31'b0, bus.pred_taken_o}, 0);
    step();
    chk("nobtb_after_pc", bus.pc_o, 32'h18);
`endif
    chk("btb_after_pred", {31'b0, bus.pred_taken_o}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
